cc_matrix_collision_scanner: RTL and testbench
==============================================

# cc_matrix_collision_scanner

Sequential, parametrised successor to the all-zero matrix comparator in the Frogger playfield path. On a start pulse it snapshots the frog layer and obstacle layer of a ROWS x DATAWIDTH LED matrix. It scans one row per clock and reports:
- whether any frog pixel overlaps an obstacle pixel (crash);
- the first colliding row;
- whether the frog layer is entirely empty (the legacy "lose" condition).

It sits between the matrix registers and the game-control FSM.

## Interface
- MATRIXCOMPARATOR_DATAWIDTH, 8, columns per row (bits per row register)
- MATRIXCOMPARATOR_ROWS, 8, number of rows scanned (>=2)
- CC_MATRIXCOMPARATOR_CLOCK_50  in  1  system clock; all logic on rising edge
- CC_MATRIXCOMPARATOR_RESET_InHigh  in  1  reset, synchronous, active-high
- CC_MATRIXCOMPARATOR_start_InHigh  in  1  scan request, sampled only in IDLE
- CC_MATRIXCOMPARATOR_frog_InBUS  in  ROWS*DATAWIDTH  frog layer; row r = bits [r*DW +: DW]
- CC_MATRIXCOMPARATOR_obstacle_InBUS  in  ROWS*DATAWIDTH  obstacle layer, same packing
- CC_MATRIXCOMPARATOR_busy_OutHigh  out  1  high in SCAN and DONE
- CC_MATRIXCOMPARATOR_done_OutHigh  out  1  one-cycle pulse, results valid
- CC_MATRIXCOMPARATOR_crash_OutHigh  out  1  collision found in last completed scan
- CC_MATRIXCOMPARATOR_empty_OutHigh  out  1  frog snapshot was all zero
- CC_MATRIXCOMPARATOR_crashrow_OutBUS  out  $clog2(ROWS)  lowest colliding row index; 0 if no crash

## Operation
- States: IDLE, SCAN, DONE. Reset state IDLE.
- IDLE + start=1 at an edge:
  - register both buses into snapshot registers;
  - register empty_next = ~|frog_InBUS;
  - clear the internal crash accumulator and found flag;
  - row counter = 0; go to SCAN.
- SCAN, each cycle:
  - hit = |(frog_snap[row] & obst_snap[row]).
  - If hit and no earlier hit: latch row into the first-row register and set found.
  - At the edge, if row == ROWS-1, go to DONE; else row += 1.
  - The counter never wraps past ROWS-1.
- DONE, one cycle:
  - done=1;
  - crash/crashrow/empty outputs take the accumulated values at the DONE edge;
  - go to IDLE.
- Result outputs hold their values until the next DONE. They do not change during a scan.
- start outside IDLE is ignored (not queued). start held high re-triggers a new scan in the cycle after DONE.
- Input buses may change freely after the start edge; only the snapshot is scanned.
- Reset at any time, including mid-scan:
  - state IDLE, row 0;
  - snapshots, accumulators and all outputs 0;
  - the scan in progress is aborted with no done pulse.
- A row with frog bits but no obstacle bits is not a crash. empty is independent of crash; both may be 0.

## Timing
- Reset values: busy=0, done=0, crash=0, empty=0, crashrow=0.
- Start sampled at edge k:
  - busy=1 from cycle k+1;
  - SCAN covers cycles k+1 .. k+ROWS;
  - DONE (done=1) is cycle k+ROWS+1;
  - updated results are visible from cycle k+ROWS+2 onward, i.e. after the DONE edge.
- Earliest next start accepted at the edge ending cycle k+ROWS+2 (IDLE).
- Full-scan latency: ROWS+2 cycles from start edge to results registered.

## Configuration
- CC_MATRIXCOMPARATOR_EARLY_ABORT_EN
  - Defined: in SCAN, a hit moves the FSM to DONE at that edge. Latency becomes (first hit row)+2 cycles; later rows are not scanned. No hit gives the full scan.
  - Undefined: all ROWS rows are always scanned; fixed latency ROWS+2.
  - crash, crashrow and empty values are identical in both builds.

## Test plan
- Reset mid-scan: start with a crash at row 5, then assert reset at cycle k+3 -> no done pulse; all outputs 0; busy=0 next cycle.
- No collision, ROWS=8, DW=8: frog row 0 = 8'h10, obstacles rows 1..7 = 8'hFF, start at k -> done at k+9; crash=0, empty=0, crashrow=0.
- Two collisions: frog row 2 = 8'h08 and row 6 = 8'h01; obstacle row 2 = 8'h0C and row 6 = 8'h01 -> crash=1, crashrow=2.
  - Done at k+9 without the macro.
  - Done at k+4 with EARLY_ABORT_EN.
- Empty frog: frog bus all zero, obstacles 8'hFF everywhere -> empty=1, crash=0 at done.
- Snapshot and start rules:
  - change the frog bus to colliding data at k+1 after a non-colliding start -> crash=0;
  - a start pulse during SCAN is ignored; exactly one done pulse.
- Back-to-back: hold start=1 -> done pulses every ROWS+2 cycles; results track the bus value at each accepted start.

Source files
------------

// File: rtl/cc_matrix_collision_scanner_if.sv
// Request/result bundle between the matrix registers, the scanner and game control.
// master drives the snapshot request; slave is the scanner side.
interface cc_matrix_collision_scanner_if #(
    parameter int MATRIXCOMPARATOR_DATAWIDTH = 8,
    parameter int MATRIXCOMPARATOR_ROWS      = 8
);
    localparam int N  = MATRIXCOMPARATOR_ROWS * MATRIXCOMPARATOR_DATAWIDTH;
    localparam int RW = $clog2(MATRIXCOMPARATOR_ROWS);

    logic          CC_MATRIXCOMPARATOR_start_InHigh;
    logic [N-1:0]  CC_MATRIXCOMPARATOR_frog_InBUS;
    logic [N-1:0]  CC_MATRIXCOMPARATOR_obstacle_InBUS;
    logic          CC_MATRIXCOMPARATOR_busy_OutHigh;
    logic          CC_MATRIXCOMPARATOR_done_OutHigh;
    logic          CC_MATRIXCOMPARATOR_crash_OutHigh;
    logic          CC_MATRIXCOMPARATOR_empty_OutHigh;
    logic [RW-1:0] CC_MATRIXCOMPARATOR_crashrow_OutBUS;

    modport master (
        output CC_MATRIXCOMPARATOR_start_InHigh,
        output CC_MATRIXCOMPARATOR_frog_InBUS,
        output CC_MATRIXCOMPARATOR_obstacle_InBUS,
        input  CC_MATRIXCOMPARATOR_busy_OutHigh,
        input  CC_MATRIXCOMPARATOR_done_OutHigh,
        input  CC_MATRIXCOMPARATOR_crash_OutHigh,
        input  CC_MATRIXCOMPARATOR_empty_OutHigh,
        input  CC_MATRIXCOMPARATOR_crashrow_OutBUS
    );

    modport slave (
        input  CC_MATRIXCOMPARATOR_start_InHigh,
        input  CC_MATRIXCOMPARATOR_frog_InBUS,
        input  CC_MATRIXCOMPARATOR_obstacle_InBUS,
        output CC_MATRIXCOMPARATOR_busy_OutHigh,
        output CC_MATRIXCOMPARATOR_done_OutHigh,
        output CC_MATRIXCOMPARATOR_crash_OutHigh,
        output CC_MATRIXCOMPARATOR_empty_OutHigh,
        output CC_MATRIXCOMPARATOR_crashrow_OutBUS
    );
endinterface

// File: rtl/cc_matrix_collision_scanner.sv
// Row-serial frog/obstacle overlap scanner with crash row and empty-frog flags.
// Optional CC_MATRIXCOMPARATOR_EARLY_ABORT_EN ends the scan at the first hit.
module cc_matrix_collision_scanner #(
    parameter int MATRIXCOMPARATOR_DATAWIDTH = 8,
    parameter int MATRIXCOMPARATOR_ROWS      = 8
) (
    input logic CC_MATRIXCOMPARATOR_CLOCK_50,
    input logic CC_MATRIXCOMPARATOR_RESET_InHigh,
    cc_matrix_collision_scanner_if.slave bus
);
    localparam int DW   = MATRIXCOMPARATOR_DATAWIDTH;
    localparam int ROWS = MATRIXCOMPARATOR_ROWS;
    localparam int RW   = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state;
    logic [ROWS-1:0][DW-1:0] frog_snap;
    logic [ROWS-1:0][DW-1:0] obst_snap;
    logic [RW-1:0]           row;
    logic [RW-1:0]           first_row;
    logic                    found;
    logic                    empty_next;
    logic                    busy;
    logic                    done;
    logic                    crash;
    logic                    empty;
    logic [RW-1:0]           crashrow;
    logic                    hit;
    logic                    last_row;

    assign hit = |(frog_snap[row] & obst_snap[row]);

`ifdef CC_MATRIXCOMPARATOR_EARLY_ABORT_EN
    assign last_row = (row == RW'(ROWS - 1)) || hit;
`else
    assign last_row = (row == RW'(ROWS - 1));
`endif

    always_ff @(posedge CC_MATRIXCOMPARATOR_CLOCK_50) begin
        if (CC_MATRIXCOMPARATOR_RESET_InHigh) begin
            state      <= IDLE;
            frog_snap  <= '0;
            obst_snap  <= '0;
            row        <= '0;
            first_row  <= '0;
            found      <= 1'b0;
            empty_next <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            crash      <= 1'b0;
            empty      <= 1'b0;
            crashrow   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.CC_MATRIXCOMPARATOR_start_InHigh) begin
                        frog_snap  <= bus.CC_MATRIXCOMPARATOR_frog_InBUS;
                        obst_snap  <= bus.CC_MATRIXCOMPARATOR_obstacle_InBUS;
                        empty_next <= ~|bus.CC_MATRIXCOMPARATOR_frog_InBUS;
                        found      <= 1'b0;
                        first_row  <= '0;
                        row        <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    // only the lowest colliding row is kept
                    if (hit && !found) begin
                        first_row <= row;
                        found     <= 1'b1;
                    end
                    if (last_row) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    crash    <= found;
                    crashrow <= first_row;
                    empty    <= empty_next;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CC_MATRIXCOMPARATOR_busy_OutHigh    = busy;
    assign bus.CC_MATRIXCOMPARATOR_done_OutHigh    = done;
    assign bus.CC_MATRIXCOMPARATOR_crash_OutHigh   = crash;
    assign bus.CC_MATRIXCOMPARATOR_empty_OutHigh   = empty;
    assign bus.CC_MATRIXCOMPARATOR_crashrow_OutBUS = crashrow;
endmodule

// File: tb/tb_cc_matrix_collision_scanner.sv
// Bench for cc_matrix_collision_scanner: reference model, per-cycle compare,
// directed scenarios and a randomized soak.
module tb_cc_matrix_collision_scanner;
    localparam int ROWS = 8;
    localparam int DW   = 8;
    localparam int N    = ROWS * DW;
    localparam int RW   = $clog2(ROWS);

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] frog  = '0;
    logic [N-1:0] obst  = '0;

    always #5 clk = ~clk;

    cc_matrix_collision_scanner_if #(
        .MATRIXCOMPARATOR_DATAWIDTH(DW),
        .MATRIXCOMPARATOR_ROWS(ROWS)
    ) bus ();

    assign bus.CC_MATRIXCOMPARATOR_start_InHigh   = start;
    assign bus.CC_MATRIXCOMPARATOR_frog_InBUS     = frog;
    assign bus.CC_MATRIXCOMPARATOR_obstacle_InBUS = obst;

    cc_matrix_collision_scanner #(
        .MATRIXCOMPARATOR_DATAWIDTH(DW),
        .MATRIXCOMPARATOR_ROWS(ROWS)
    ) dut (
        .CC_MATRIXCOMPARATOR_CLOCK_50(clk),
        .CC_MATRIXCOMPARATOR_RESET_InHigh(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: results computed from the snapshot at accept time,
    // done scheduled at an absolute cycle number.
    int            cyc     = 0;
    int            done_at = 0;
    bit            active  = 1'b0;
    logic          exp_busy = 1'b0, exp_done = 1'b0;
    logic          exp_crash = 1'b0, exp_empty = 1'b0;
    logic [RW-1:0] exp_row = '0;
    logic          p_crash, p_empty;
    logic [RW-1:0] p_row;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            active    = 1'b0;
            exp_crash = 1'b0;
            exp_empty = 1'b0;
            exp_row   = '0;
        end else if (active && cyc == done_at) begin
            active    = 1'b0;
            exp_crash = p_crash;
            exp_empty = p_empty;
            exp_row   = p_row;
        end else if (!active && start) begin
            p_crash = 1'b0;
            p_row   = '0;
            p_empty = (frog == '0);
            done_at = cyc + ROWS + 1;
            for (int r = ROWS - 1; r >= 0; r--)
                if ((frog[r*DW +: DW] & obst[r*DW +: DW]) != '0) begin
                    p_crash = 1'b1;
                    p_row   = RW'(r);
                end
`ifdef CC_MATRIXCOMPARATOR_EARLY_ABORT_EN
            if (p_crash) done_at = cyc + int'(p_row) + 2;
`endif
            active = 1'b1;
        end
        cyc++;
        exp_busy = active;
        exp_done = active && (cyc == done_at);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", bus.CC_MATRIXCOMPARATOR_busy_OutHigh, exp_busy);
            check("done", bus.CC_MATRIXCOMPARATOR_done_OutHigh, exp_done);
            check("crash", bus.CC_MATRIXCOMPARATOR_crash_OutHigh, exp_crash);
            check("empty", bus.CC_MATRIXCOMPARATOR_empty_OutHigh, exp_empty);
            check("crashrow", bus.CC_MATRIXCOMPARATOR_crashrow_OutBUS, exp_row);
        end
    end

    function automatic logic [N-1:0] rand_frog();
        logic [N-1:0] v;
        v = '0;
        if ($urandom_range(0, 7) != 0)
            for (int r = 0; r < ROWS; r++)
                v[r*DW +: DW] = DW'($urandom & $urandom & $urandom);
        return v;
    endfunction

    function automatic logic [N-1:0] rand_obst();
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            if ($urandom_range(0, 2) == 0) v[r*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic run_scan(input string nm, input logic [N-1:0] f,
                            input logic [N-1:0] o, input logic [N-1:0] f_after,
                            input int exp_n, input logic ec,
                            input logic [RW-1:0] er, input logic ee);
        int n;
        bit seen;
        @(negedge clk);
        frog  = f;
        obst  = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frog  = f_after;
        n     = 1;
        seen  = 1'b0;
        while (!seen && n < 40) begin
            if (bus.CC_MATRIXCOMPARATOR_done_OutHigh) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_latency"}, n, exp_n);
        @(negedge clk);
        check({nm, "_crash"}, bus.CC_MATRIXCOMPARATOR_crash_OutHigh, ec);
        check({nm, "_crashrow"}, bus.CC_MATRIXCOMPARATOR_crashrow_OutBUS, er);
        check({nm, "_empty"}, bus.CC_MATRIXCOMPARATOR_empty_OutHigh, ee);
    endtask

    initial begin
        logic [N-1:0] f, o, f2;
        int ndone, last;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", bus.CC_MATRIXCOMPARATOR_busy_OutHigh, 0);
        check("rst_done", bus.CC_MATRIXCOMPARATOR_done_OutHigh, 0);
        check("rst_crash", bus.CC_MATRIXCOMPARATOR_crash_OutHigh, 0);
        check("rst_empty", bus.CC_MATRIXCOMPARATOR_empty_OutHigh, 0);
        check("rst_crashrow", bus.CC_MATRIXCOMPARATOR_crashrow_OutBUS, 0);
        rst = 1'b0;

        f = '0;
        f[0 +: DW] = 8'h10;
        o = '1;
        o[0 +: DW] = 8'h00;
        run_scan("nocoll", f, o, f, 9, 1'b0, '0, 1'b0);

        f = '0;
        o = '0;
        f[2*DW +: DW] = 8'h08;
        f[6*DW +: DW] = 8'h01;
        o[2*DW +: DW] = 8'h0C;
        o[6*DW +: DW] = 8'h01;
`ifdef CC_MATRIXCOMPARATOR_EARLY_ABORT_EN
        run_scan("twocoll", f, o, f, 4, 1'b1, RW'(2), 1'b0);
`else
        run_scan("twocoll", f, o, f, 9, 1'b1, RW'(2), 1'b0);
`endif

        f = '0;
        o = '0;
        f[5*DW +: DW] = 8'h01;
        o[5*DW +: DW] = 8'h01;
        @(negedge clk);
        frog  = f;
        obst  = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", bus.CC_MATRIXCOMPARATOR_busy_OutHigh, 0);
        check("midrst_crash", bus.CC_MATRIXCOMPARATOR_crash_OutHigh, 0);
        check("midrst_crashrow", bus.CC_MATRIXCOMPARATOR_crashrow_OutBUS, 0);
        ndone = 0;
        repeat (12) begin
            if (bus.CC_MATRIXCOMPARATOR_done_OutHigh) ndone++;
            @(negedge clk);
        end
        check("midrst_nodone", ndone, 0);

        run_scan("empty", '0, '1, '0, 9, 1'b0, '0, 1'b1);

        f = '0;
        o = '0;
        f[3*DW +: DW] = 8'h01;
        o[4*DW +: DW] = 8'h01;
        f2 = f;
        f2[4*DW +: DW] = 8'h01;
        run_scan("snapshot", f, o, f2, 9, 1'b0, '0, 1'b0);

        @(negedge clk);
        frog  = f;
        obst  = '1;
        obst[3*DW +: DW] = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (16) begin
            if (bus.CC_MATRIXCOMPARATOR_done_OutHigh) ndone++;
            @(negedge clk);
        end
        check("ignore_start_pulses", ndone, 1);

        // collisions only possible in the last row keep the period fixed in both builds
        @(negedge clk);
        obst = '0;
        obst[(ROWS-1)*DW +: DW] = '1;
        frog  = rand_frog();
        start = 1'b1;
        ndone = 0;
        last  = 0;
        for (int i = 0; i < 4 * (ROWS + 2) + 2; i++) begin
            @(negedge clk);
            frog = rand_frog();
            if (bus.CC_MATRIXCOMPARATOR_done_OutHigh) begin
                if (ndone > 0) check("b2b_period", cyc - last, ROWS + 2);
                last = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", ndone, 4);
        repeat (ROWS + 4) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) begin
                frog = rand_frog();
                obst = rand_obst();
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (ROWS + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
